// File: rtl/usb_m4_byte_fifo.sv
// Single-clock FWFT byte FIFO between the USB serial engine and the M4 register block.
// Flags and the 4-bit fill codes decode from the registered occupancy count.
module usb_m4_byte_fifo #(
    parameter int DEPTH_LOG2 = 8,
    parameter int AE_LEVEL   = 4,
    parameter int AF_LEVEL   = 252
) (
    input  logic                  WBs_CLK_i,
    input  logic                  WBs_RST_n_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [7:0]            din_i,
    input  logic                  pop_i,
    output logic [7:0]            dout_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  ae_o,
    output logic                  af_o,
    output logic [3:0]            popflag_o,
    output logic [3:0]            pushflag_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t D_C  = cnt_t'(DEPTH);
    localparam cnt_t Q1_C = cnt_t'(DEPTH / 4);
    localparam cnt_t Q2_C = cnt_t'(DEPTH / 2);
    localparam cnt_t Q3_C = cnt_t'((3 * DEPTH) / 4);
    localparam cnt_t AE_C = cnt_t'(AE_LEVEL);
    localparam cnt_t AF_C = cnt_t'(AF_LEVEL);
    localparam cnt_t ONE  = cnt_t'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    cnt_t                  count;
    cnt_t                  free;
    logic                  pop_acc;
    logic                  push_acc;

    // Ranges are disjoint so the decoder stays a true one-hot select.
    function automatic logic [3:0] fill_code(input cnt_t n);
        logic [3:0] c;
        c = 4'h6;
        unique case (1'b1)
            (n == '0):               c = 4'h0;
            (n == ONE):              c = 4'h1;
            (n > ONE && n < Q1_C):   c = 4'h2;
            (n >= Q1_C && n < Q2_C): c = 4'h3;
            (n >= Q2_C && n < Q3_C): c = 4'h4;
            (n >= Q3_C && n < D_C):  c = 4'h5;
            default:                 c = 4'h6;
        endcase
        return c;
    endfunction

    assign empty_o  = (count == '0);
    assign full_o   = (count == D_C);
    assign ae_o     = (count <= AE_C);
    assign af_o     = (count >= AF_C);
    assign free     = D_C - count;

    assign popflag_o  = fill_code(count);
    assign pushflag_o = fill_code(free);
    assign count_o    = count;

    assign pop_acc  = pop_i && !empty_o;
    assign push_acc = push_i && (!full_o || pop_acc);

    assign dout_o = empty_o ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge WBs_CLK_i) begin
        if (push_acc && !flush_i) begin
            mem[wr_ptr] <= din_i;
        end
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (flush_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + cnt_t'(push_acc) - cnt_t'(pop_acc);
            if (push_i && !push_acc) begin
                overflow_o <= 1'b1;
            end
            if (pop_i && !pop_acc) begin
                underflow_o <= 1'b1;
            end
        end
    end

endmodule
